// File: rtl/noc_axilite_resp_bridge.sv
// noc_axilite_resp_bridge
// Turns noc3 response messages (NC_LOAD_MEM_ACK / NC_STORE_MEM_ACK) back into
// AXI-Lite R and B beats. Headers are decoded, payload flits are stripped, and
// each completed response is buffered in its own per-channel queue.
// Optional feature macro: NOC_RESP_ERRCNT_EN adds the err_count port, a
// saturating count of dropped messages.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_TYPE
`define MSG_TYPE 21:14
`endif
`ifndef MSG_TYPE_NC_LOAD_MEM_ACK
`define MSG_TYPE_NC_LOAD_MEM_ACK 8'd26
`endif
`ifndef MSG_TYPE_NC_STORE_MEM_ACK
`define MSG_TYPE_NC_STORE_MEM_ACK 8'd27
`endif

module noc_axilite_resp_bridge #(
  parameter int DATA_W  = `NOC_DATA_WIDTH,
  parameter int R_DEPTH = 4,
  parameter int B_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              noc3_valid_in,
  input  logic [DATA_W-1:0] noc3_data_in,
  output logic              noc3_ready_out,
  output logic [DATA_W-1:0] m_axi_rdata,
  output logic [1:0]        m_axi_rresp,
  output logic              m_axi_rvalid,
  input  logic              m_axi_rready,
  output logic [1:0]        m_axi_bresp,
  output logic              m_axi_bvalid,
  input  logic              m_axi_bready
`ifdef NOC_RESP_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int RAW = $clog2(R_DEPTH);
  localparam int RCW = RAW + 1;
  localparam int BAW = $clog2(B_DEPTH);
  localparam int BCW = BAW + 1;

  typedef enum logic [0:0] {HDR, PAYLOAD} state_t;

  state_t              state_q, state_d;
  logic [7:0]          remaining_q, remaining_d;
  logic                is_load_q, is_load_d;
  logic                first_pending_q, first_pending_d;
  logic [DATA_W-1:0]   hold_q, hold_d;

  logic [7:0]          hdr_len;
  logic [7:0]          hdr_type;
  logic                flit_acc;
  logic                r_push, b_push, r_pop, b_pop;
  logic [DATA_W-1:0]   r_push_data;
  logic [1:0]          r_push_resp;
  logic                drop_evt;

  logic [DATA_W+1:0]   r_mem [R_DEPTH];
  logic [RAW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [RCW-1:0]      r_count;
  logic                r_full, r_empty;

  logic [1:0]          b_mem [B_DEPTH];
  logic [BAW-1:0]      b_wr_ptr, b_rd_ptr;
  logic [BCW-1:0]      b_count;
  logic                b_full, b_empty;

  assign hdr_len  = noc3_data_in[`MSG_LENGTH];
  assign hdr_type = noc3_data_in[`MSG_TYPE];

  assign r_full  = (r_count == RCW'(R_DEPTH));
  assign r_empty = (r_count == '0);
  assign b_full  = (b_count == BCW'(B_DEPTH));
  assign b_empty = (b_count == '0);

  // Headers wait for room in both queues; payload flits are always taken.
  always_comb begin
    noc3_ready_out = 1'b0;
    if (!rst) begin
      if (state_q == HDR) noc3_ready_out = !r_full && !b_full;
      else                noc3_ready_out = 1'b1;
    end
  end

  assign flit_acc = noc3_valid_in && noc3_ready_out;

  // Next-state logic: header decode, payload counting and queue pushes.
  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    is_load_d       = is_load_q;
    first_pending_d = first_pending_q;
    hold_d          = hold_q;
    r_push          = 1'b0;
    r_push_data     = '0;
    r_push_resp     = RESP_OKAY;
    b_push          = 1'b0;
    drop_evt        = 1'b0;
    case (state_q)
      HDR: begin
        if (flit_acc) begin
          remaining_d     = hdr_len;
          first_pending_d = 1'b1;
          is_load_d       = 1'b0;
          if (hdr_type == `MSG_TYPE_NC_STORE_MEM_ACK) begin
            b_push = 1'b1;
            if (hdr_len != 8'd0) state_d = PAYLOAD;
          end else if (hdr_type == `MSG_TYPE_NC_LOAD_MEM_ACK) begin
            if (hdr_len == 8'd0) begin
              r_push      = 1'b1;
              r_push_resp = RESP_SLVERR;
              drop_evt    = 1'b1;
            end else begin
              is_load_d = 1'b1;
              state_d   = PAYLOAD;
            end
          end else begin
            drop_evt = 1'b1;
            if (hdr_len != 8'd0) state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (flit_acc) begin
          if (remaining_q != 8'd0) remaining_d = remaining_q - 8'd1;
          if (first_pending_q) begin
            hold_d          = noc3_data_in;
            first_pending_d = 1'b0;
          end
          if (remaining_q <= 8'd1) begin
            state_d = HDR;
            if (is_load_q) begin
              r_push      = 1'b1;
              r_push_data = first_pending_q ? noc3_data_in : hold_q;
              r_push_resp = RESP_OKAY;
            end
          end
        end
      end
      default: state_d = HDR;
    endcase
  end

  // Message-parsing state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= HDR;
      remaining_q     <= 8'd0;
      is_load_q       <= 1'b0;
      first_pending_q <= 1'b0;
      hold_q          <= '0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      is_load_q       <= is_load_d;
      first_pending_q <= first_pending_d;
      hold_q          <= hold_d;
    end
  end

  assign r_pop = m_axi_rvalid && m_axi_rready;
  assign b_pop = m_axi_bvalid && m_axi_bready;

  // Read-response queue storage; entries are {resp, data}.
  always_ff @(posedge clk) begin
    if (r_push) r_mem[r_wr_ptr] <= {r_push_resp, r_push_data};
  end

  // Read-response queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (r_push) r_wr_ptr <= r_wr_ptr + RAW'(1);
      if (r_pop)  r_rd_ptr <= r_rd_ptr + RAW'(1);
      case ({r_push, r_pop})
        2'b10:   r_count <= r_count + RCW'(1);
        2'b01:   r_count <= r_count - RCW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write-response queue storage; every store ack completes OKAY.
  always_ff @(posedge clk) begin
    if (b_push) b_mem[b_wr_ptr] <= RESP_OKAY;
  end

  // Write-response queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_wr_ptr <= '0;
      b_rd_ptr <= '0;
      b_count  <= '0;
    end else begin
      if (b_push) b_wr_ptr <= b_wr_ptr + BAW'(1);
      if (b_pop)  b_rd_ptr <= b_rd_ptr + BAW'(1);
      case ({b_push, b_pop})
        2'b10:   b_count <= b_count + BCW'(1);
        2'b01:   b_count <= b_count - BCW'(1);
        default: b_count <= b_count;
      endcase
    end
  end

  // Head entries drive the AXI side; idle outputs read as zero.
  assign m_axi_rvalid = !r_empty;
  assign m_axi_bvalid = !b_empty;
  assign m_axi_rdata  = m_axi_rvalid ? r_mem[r_rd_ptr][DATA_W-1:0]      : '0;
  assign m_axi_rresp  = m_axi_rvalid ? r_mem[r_rd_ptr][DATA_W+1:DATA_W] : 2'b00;
  assign m_axi_bresp  = m_axi_bvalid ? b_mem[b_rd_ptr]                  : 2'b00;

`ifdef NOC_RESP_ERRCNT_EN
  // Saturating count of dropped messages, bumped at header accept.
  always_ff @(posedge clk) begin
    if (rst)                                err_count <= 16'd0;
    else if (drop_evt && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
`endif

endmodule

// File: tb/tb_noc_axilite_resp_bridge.sv
// tb_noc_axilite_resp_bridge
// Directed scenarios plus randomized message traffic for the noc3 response
// bridge. A message-level model predicts the R/B beat sequence, header
// back-pressure and (with NOC_RESP_ERRCNT_EN) the dropped-message count.

module tb_noc_axilite_resp_bridge;

  localparam int DW = 64;
  localparam int RD = 4;
  localparam int BD = 4;
  localparam logic [7:0] T_LOAD  = 8'd26;
  localparam logic [7:0] T_STORE = 8'd27;

  logic          clk = 1'b0;
  logic          rst;
  logic          noc3_valid_in;
  logic [DW-1:0] noc3_data_in;
  logic          noc3_ready_out;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
`ifdef NOC_RESP_ERRCNT_EN
  logic [15:0]   err_count;
`endif

  noc_axilite_resp_bridge #(.DATA_W(DW), .R_DEPTH(RD), .B_DEPTH(BD)) dut (
    .clk            (clk),
    .rst            (rst),
    .noc3_valid_in  (noc3_valid_in),
    .noc3_data_in   (noc3_data_in),
    .noc3_ready_out (noc3_ready_out),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready),
    .m_axi_bresp    (m_axi_bresp),
    .m_axi_bvalid   (m_axi_bvalid),
    .m_axi_bready   (m_axi_bready)
`ifdef NOC_RESP_ERRCNT_EN
    ,
    .err_count      (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } rbeat_t;

  rbeat_t     rq[$];
  logic [1:0] bq[$];
  int         model_err   = 0;
  bit         in_payload  = 0;
  bit         mon_on      = 0;
  bit         random_ready = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finishRun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Offers one flit from posedge+1 and returns at the posedge that accepts it.
  task automatic sendFlit(input logic [63:0] d);
    bit ok;
    ok = 0;
    noc3_valid_in = 1'b1;
    noc3_data_in  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (noc3_ready_out) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL flit_accept_timeout actual=stalled expected=accepted");
      finishRun();
    end
    @(posedge clk);
  endtask

  // Sends one whole message and records what it must produce on R/B.
  task automatic applyStimulus(input logic [7:0] mtype, input logic [7:0] len,
                               input logic [63:0] first);
    logic [63:0] hdr;
    logic [63:0] pay;
    hdr = {$urandom, $urandom};
    hdr[29:22] = len;
    hdr[21:14] = mtype;
    sendFlit(hdr);
    if (mtype == T_STORE) begin
      bq.push_back(2'b00);
    end else if (mtype == T_LOAD) begin
      if (len == 8'd0) begin
        rq.push_back('{data: 64'd0, resp: 2'b10});
        if (model_err < 65535) model_err++;
      end
    end else begin
      if (model_err < 65535) model_err++;
    end
    if (len != 8'd0) in_payload = 1;
    #1;
    for (int k = 1; k <= int'(len); k++) begin
      pay = (k == 1) ? first : {$urandom, $urandom};
      sendFlit(pay);
      if (k == int'(len)) begin
        in_payload = 0;
        if (mtype == T_LOAD) rq.push_back('{data: first, resp: 2'b00});
      end
      #1;
    end
    noc3_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every-cycle comparison of the DUT against the message-level model.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      bit exp_ready;
      exp_ready = in_payload ? 1'b1 : (rq.size() < RD && bq.size() < BD);
      checkOutput("ready_out", noc3_ready_out, exp_ready);
      checkOutput("rvalid", m_axi_rvalid, rq.size() != 0);
      if (m_axi_rvalid && rq.size() != 0) begin
        checkOutput("rdata", m_axi_rdata, rq[0].data);
        checkOutput("rresp", m_axi_rresp, rq[0].resp);
        if (m_axi_rready) void'(rq.pop_front());
      end
      checkOutput("bvalid", m_axi_bvalid, bq.size() != 0);
      if (m_axi_bvalid && bq.size() != 0) begin
        checkOutput("bresp", m_axi_bresp, bq[0]);
        if (m_axi_bready) void'(bq.pop_front());
      end
`ifdef NOC_RESP_ERRCNT_EN
      checkOutput("err_count", err_count, model_err);
`endif
    end
  end

  // Random AXI back-pressure during the random phase.
  always @(posedge clk) begin
    if (random_ready) begin
      #1;
      m_axi_rready = ($urandom_range(0, 3) != 0);
      m_axi_bready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("[TB] FAIL global_timeout actual=running expected=done");
    finishRun();
  end

  initial begin
    logic [63:0] d4 [5];
    logic [7:0]  mt;
    int          sel;
    bit          drained;

    rst = 1'b1;
    noc3_valid_in = 1'b0;
    noc3_data_in  = '0;
    m_axi_rready  = 1'b0;
    m_axi_bready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", noc3_ready_out, 0);
    checkOutput("rst_rvalid", m_axi_rvalid, 0);
    checkOutput("rst_bvalid", m_axi_bvalid, 0);
    checkOutput("rst_rdata", m_axi_rdata, 0);
    checkOutput("rst_rresp", m_axi_rresp, 0);
    checkOutput("rst_bresp", m_axi_bresp, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1;
    m_axi_rready = 1'b1;
    m_axi_bready = 1'b1;
    idle(1);

    // T1: store ack, no payload
    applyStimulus(T_STORE, 8'd0, 64'd0);
    @(negedge clk);
    checkOutput("t1_bvalid", m_axi_bvalid, 1);
    checkOutput("t1_bresp", m_axi_bresp, 2'b00);
    @(negedge clk);
    checkOutput("t1_single_beat", m_axi_bvalid, 0);
    idle(1);

    // T2: load ack, one payload flit
    applyStimulus(T_LOAD, 8'd1, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    checkOutput("t2_rvalid", m_axi_rvalid, 1);
    checkOutput("t2_rdata", m_axi_rdata, 64'hDEADBEEF_CAFEF00D);
    checkOutput("t2_rresp", m_axi_rresp, 2'b00);
    idle(2);

    // T3: load ack, three payload flits, only the first is returned
    applyStimulus(T_LOAD, 8'd3, 64'hAAAA_0000_1111_AAAA);
    @(negedge clk);
    checkOutput("t3_rdata", m_axi_rdata, 64'hAAAA_0000_1111_AAAA);
    @(negedge clk);
    checkOutput("t3_single_beat", m_axi_rvalid, 0);
    checkOutput("t3_back_in_hdr", noc3_ready_out, 1);
    idle(1);

    // T4: fill the read queue, the fifth header stalls until one pop
    m_axi_rready = 1'b0;
    for (int i = 0; i < 5; i++) d4[i] = 64'h4400_0000_0000_0000 | 64'(i + 1);
    for (int i = 0; i < 4; i++) applyStimulus(T_LOAD, 8'd1, d4[i]);
    fork
      applyStimulus(T_LOAD, 8'd1, d4[4]);
      begin
        @(negedge clk);
        checkOutput("t4_head", m_axi_rdata, d4[0]);
        checkOutput("t4_stall0", noc3_ready_out, 0);
        repeat (2) begin
          @(negedge clk);
          checkOutput("t4_stall", noc3_ready_out, 0);
        end
        @(posedge clk); #1;
        m_axi_rready = 1'b1;
        @(negedge clk);
        checkOutput("t4_pop_cycle_ready", noc3_ready_out, 0);
        @(posedge clk); #1;
        m_axi_rready = 1'b0;
        @(negedge clk);
        checkOutput("t4_ready_after_pop", noc3_ready_out, 1);
      end
    join
    idle(1);
    m_axi_rready = 1'b1;
    idle(8);

    // T5: unknown type with two payload flits is drained and counted
    applyStimulus(8'd99, 8'd2, 64'h5555);
    @(negedge clk);
    checkOutput("t5_no_r", m_axi_rvalid, 0);
    checkOutput("t5_no_b", m_axi_bvalid, 0);
`ifdef NOC_RESP_ERRCNT_EN
    checkOutput("t5_err_count", err_count, 16'd1);
`endif
    idle(1);

    // Load ack with no payload returns SLVERR with zero data
    applyStimulus(T_LOAD, 8'd0, 64'd0);
    @(negedge clk);
    checkOutput("len0_rvalid", m_axi_rvalid, 1);
    checkOutput("len0_rresp", m_axi_rresp, 2'b10);
    checkOutput("len0_rdata", m_axi_rdata, 64'd0);
    idle(2);

    // T6: reset in the middle of a load message
    begin
      logic [63:0] hdr;
      hdr = 64'd0;
      hdr[29:22] = 8'd3;
      hdr[21:14] = T_LOAD;
      sendFlit(hdr);
      in_payload = 1;
      #1;
      sendFlit(64'h6666_6666_6666_6666);
      #1;
      noc3_valid_in = 1'b0;
      rst = 1'b1;
      rq.delete();
      bq.delete();
      in_payload = 0;
      model_err = 0;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6_no_rvalid", m_axi_rvalid, 0);
      checkOutput("t6_ready", noc3_ready_out, 1);
      idle(1);
      applyStimulus(T_STORE, 8'd0, 64'd0);
      @(negedge clk);
      checkOutput("t6_store_bvalid", m_axi_bvalid, 1);
      idle(2);
    end

    // Random traffic under random back-pressure
    random_ready = 1;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      mt = T_LOAD;
      else if (sel < 8) mt = T_STORE;
      else begin
        mt = 8'($urandom_range(0, 255));
        if (mt == T_LOAD || mt == T_STORE) mt = 8'd7;
      end
      applyStimulus(mt, 8'($urandom_range(0, 4)), {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    random_ready = 0;
    repeat (2) @(posedge clk);
    #2;
    m_axi_rready = 1'b1;
    m_axi_bready = 1'b1;
    drained = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rq.size() == 0 && bq.size() == 0) begin
        drained = 1;
        break;
      end
    end
    checkOutput("drain_done", drained, 1);
    idle(2);
    finishRun();
  end

endmodule
